// File: rtl/sdram_sched_pkg.sv
// Shared definitions for the SDRAM frame scheduler: FSM state encoding,
// reset values of the triple-buffer indices and the frame base-address table.
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

    // After reset the camera writes buffer 0, buffer 1 is the (empty) latest
    // frame and the display shows buffer 2.
    localparam logic [1:0] WR_IDX_RST     = 2'd0;
    localparam logic [1:0] LATEST_IDX_RST = 2'd1;
    localparam logic [1:0] DISP_IDX_RST   = 2'd2;

    // Base burst address of buffer idx. Each entry is a constant multiple of the
    // frame size, so callers get a small constant mux rather than a multiplier.
    function automatic int base_addr(input logic [1:0] idx, input int bursts);
        case (idx)
            2'd0:    return 0;
            2'd1:    return bursts;
            2'd2:    return bursts + bursts;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/sdram_frame_scheduler_if.sv
// Burst request handshake between the frame scheduler and the SDRAM controller.
// The scheduler side is the master: it raises rw_en for one cycle with rw and
// f_addr, and watches ready to follow the controller through the burst.
interface sdram_frame_scheduler_if #(
    parameter int ADDR_W = 15
);
    logic              ready;
    logic              rw_en;
    logic              rw;
    logic [ADDR_W-1:0] f_addr;

    modport master (input ready, output rw_en, output rw, output f_addr);
    modport slave  (output ready, input rw_en, input rw, input f_addr);

endinterface

// File: rtl/sdram_frame_scheduler_triple_buffer_mgr.sv
// Triple-buffer bookkeeping: keeps the write, latest and display indices as a
// permutation of {0,1,2}, so the display never sees a frame still being written.
module triple_buffer_mgr
    import sdram_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cam_frame_start,
    input  logic       vga_frame_start,
    input  logic       wr_full,
    input  logic       wr_partial,
    output logic [1:0] wr_idx,
    output logic [1:0] disp_idx,
    output logic [7:0] frame_drops
);

    logic [1:0] latest_idx;
    logic       new_valid;

    logic [1:0] wr_nxt;
    logic [1:0] latest_mid;
    logic [1:0] latest_nxt;
    logic [1:0] disp_nxt;
    logic       valid_mid;
    logic       valid_nxt;
    logic [7:0] drops_nxt;

    // Camera swap is resolved first, so a display swap in the same cycle picks
    // up the frame that has just been completed.
    always_comb begin
        wr_nxt     = wr_idx;
        latest_mid = latest_idx;
        valid_mid  = new_valid;
        drops_nxt  = frame_drops;
        if (cam_frame_start) begin
            if (wr_full) begin
                wr_nxt     = latest_idx;
                latest_mid = wr_idx;
                valid_mid  = 1'b1;
            end else if (wr_partial && (frame_drops != 8'hFF)) begin
                drops_nxt = frame_drops + 8'd1;
            end
        end
        latest_nxt = latest_mid;
        disp_nxt   = disp_idx;
        valid_nxt  = valid_mid;
        if (vga_frame_start && valid_mid) begin
            disp_nxt   = latest_mid;
            latest_nxt = disp_idx;
            valid_nxt  = 1'b0;
        end
    end

    // Register the buffer indices, the new-frame flag and the drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx      <= WR_IDX_RST;
            latest_idx  <= LATEST_IDX_RST;
            disp_idx    <= DISP_IDX_RST;
            new_valid   <= 1'b0;
            frame_drops <= 8'd0;
        end else begin
            wr_idx      <= wr_nxt;
            latest_idx  <= latest_nxt;
            disp_idx    <= disp_nxt;
            new_valid   <= valid_nxt;
            frame_drops <= drops_nxt;
        end
    end

endmodule

// File: rtl/sdram_frame_scheduler.sv
// Arbitrates camera write bursts against display read bursts into the SDRAM
// controller and generates their addresses inside the triple-buffered frames.
module sdram_frame_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int WR_THRESH        = 512,
    parameter int RD_THRESH        = 250,
    parameter int BURSTS_PER_FRAME = 600,
    parameter int MAX_WR_STREAK    = 4,
    parameter int ACK_TIMEOUT      = 8,
    parameter int ADDR_W           = 15,
    parameter int FILL_W           = 10
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FILL_W-1:0] wr_fill,
    input  logic [FILL_W-1:0] rd_fill,
    input  logic              cam_frame_start,
    input  logic              vga_frame_start,
    sdram_frame_scheduler_if.master bus,
    output logic [1:0]        disp_buf,
    output logic [7:0]        frame_drops,
    output logic              ack_err
);

    localparam int CNT_W    = $clog2(BURSTS_PER_FRAME + 1);
    localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);
    localparam int TMO_W    = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(BURSTS_PER_FRAME);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [FILL_W-1:0]   WR_LIM     = FILL_W'(WR_THRESH);
    localparam logic [FILL_W-1:0]   RD_LIM     = FILL_W'(RD_THRESH);

    sched_state_t        state;
    logic [CNT_W-1:0]    wr_cnt;
    logic [CNT_W-1:0]    rd_cnt;
    logic [STREAK_W-1:0] wr_streak;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [1:0]          wr_idx;
    logic [1:0]          disp_idx;

    logic wr_ok;
    logic rd_ok;
    logic pick_write;

    function automatic logic [ADDR_W-1:0] frame_base(input logic [1:0] idx);
        return ADDR_W'(base_addr(idx, BURSTS_PER_FRAME));
    endfunction

    assign wr_ok      = (wr_fill > WR_LIM) && (wr_cnt < CNT_FULL);
    assign rd_ok      = (rd_fill < RD_LIM) && (rd_cnt < CNT_FULL);
    assign pick_write = wr_ok && !(rd_ok && (wr_streak >= STREAK_MAX));
    assign disp_buf   = disp_idx;

    triple_buffer_mgr u_buf_mgr (
        .clk             (clk),
        .rst_n           (rst_n),
        .cam_frame_start (cam_frame_start),
        .vga_frame_start (vga_frame_start),
        .wr_full         (wr_cnt == CNT_FULL),
        .wr_partial      (wr_cnt != '0),
        .wr_idx          (wr_idx),
        .disp_idx        (disp_idx),
        .frame_drops     (frame_drops)
    );

    // Burst sequencer: decide, pulse rw_en, then follow ready low and high again.
    // Frame-start counter clears come last so they override a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus.rw_en  <= 1'b0;
            bus.rw     <= 1'b0;
            bus.f_addr <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            wr_streak  <= '0;
            tmo_cnt    <= '0;
            ack_err    <= 1'b0;
        end else begin
            bus.rw_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ready && (wr_ok || rd_ok)) begin
                        state     <= ISSUE;
                        bus.rw_en <= 1'b1;
                        if (pick_write) begin
                            bus.rw     <= 1'b0;
                            bus.f_addr <= frame_base(wr_idx) + ADDR_W'(wr_cnt);
                            wr_cnt     <= wr_cnt + CNT_W'(1);
                            if (wr_streak < STREAK_MAX) begin
                                wr_streak <= wr_streak + STREAK_W'(1);
                            end
                        end else begin
                            bus.rw     <= 1'b1;
                            bus.f_addr <= frame_base(disp_idx) + ADDR_W'(rd_cnt);
                            rd_cnt     <= rd_cnt + CNT_W'(1);
                            wr_streak  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    state   <= WAIT_ACK;
                    tmo_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (!bus.ready) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        ack_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (bus.ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (cam_frame_start) begin
                wr_cnt <= '0;
            end
            if (vga_frame_start) begin
                rd_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_frame_scheduler.sv
// Directed bench for sdram_frame_scheduler with a small SDRAM controller model
// that drops ready for five cycles after every request.
module tb_sdram_frame_scheduler;

    logic       clk;
    logic       rst_n;
    logic [9:0] wr_fill;
    logic [9:0] rd_fill;
    logic       cam_frame_start;
    logic       vga_frame_start;
    logic [1:0] disp_buf;
    logic [7:0] frame_drops;
    logic       ack_err;

    int n_compared;
    int n_mismatch;
    int mode;
    int busy;

    sdram_frame_scheduler_if #(.ADDR_W(15)) bus ();

    sdram_frame_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_fill         (wr_fill),
        .rd_fill         (rd_fill),
        .cam_frame_start (cam_frame_start),
        .vga_frame_start (vga_frame_start),
        .bus             (bus),
        .disp_buf        (disp_buf),
        .frame_drops     (frame_drops),
        .ack_err         (ack_err)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controller model, updated on the falling edge. Mode 0: busy for five
    // cycles after each request; mode 1: ready held high; mode 2: held low.
    initial begin
        busy      = 0;
        bus.ready = 1'b1;
        forever begin
            @(negedge clk);
            case (mode)
                1: begin
                    busy      = 0;
                    bus.ready = 1'b1;
                end
                2: begin
                    busy      = 0;
                    bus.ready = 1'b0;
                end
                default: begin
                    if (bus.rw_en) busy = 5;
                    else if (busy > 0) busy--;
                    bus.ready = (busy == 0);
                end
            endcase
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next request, check its type and address, and
    // check that rw_en is gone again one cycle later.
    task automatic wait_burst(input logic exp_rw, input int exp_addr, input string tag);
        int waited;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!bus.rw_en && waited < 40);
        check_output({tag, "_seen"}, 32'(bus.rw_en), 32'd1);
        if (bus.rw_en) begin
            check_output({tag, "_rw"}, 32'(bus.rw), 32'(exp_rw));
            check_output({tag, "_addr"}, 32'(bus.f_addr), 32'(exp_addr));
            @(posedge clk);
            #1;
            check_output({tag, "_pulse"}, 32'(bus.rw_en), 32'd0);
        end
    endtask

    task automatic apply_stimulus(input logic cam, input logic vga);
        cam_frame_start = cam;
        vga_frame_start = vga;
        @(posedge clk);
        #1;
        cam_frame_start = 1'b0;
        vga_frame_start = 1'b0;
    endtask

    task automatic go_quiet();
        wr_fill = 10'd0;
        rd_fill = 10'd300;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared      = 0;
        n_mismatch      = 0;
        mode            = 0;
        rst_n           = 1'b0;
        wr_fill         = 10'd0;
        rd_fill         = 10'd300;
        cam_frame_start = 1'b0;
        vga_frame_start = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_rw_en", 32'(bus.rw_en), 32'd0);
        check_output("rst_rw", 32'(bus.rw), 32'd0);
        check_output("rst_addr", 32'(bus.f_addr), 32'd0);
        check_output("rst_disp", 32'(disp_buf), 32'd2);
        check_output("rst_drops", 32'(frame_drops), 32'd0);
        check_output("rst_ackerr", 32'(ack_err), 32'd0);
        rst_n = 1'b1;

        // Write-only traffic fills buffer 0 completely: addresses 0..599
        wr_fill = 10'd600;
        for (int i = 0; i < 600; i++) wait_burst(1'b0, i, $sformatf("wr0_%0d", i));
        go_quiet();

        // Completed frame: camera swap, then display picks up buffer 0
        apply_stimulus(1'b1, 1'b0);
        check_output("cam_swap_disp", 32'(disp_buf), 32'd2);
        apply_stimulus(1'b0, 1'b1);
        check_output("vga_swap_disp", 32'(disp_buf), 32'd0);

        // Writes continue in buffer 1; abandon the frame after 300 bursts
        wr_fill = 10'd600;
        for (int i = 0; i < 300; i++) wait_burst(1'b0, 600 + i, $sformatf("wr1a_%0d", i));
        go_quiet();
        apply_stimulus(1'b1, 1'b0);
        check_output("drop_count", 32'(frame_drops), 32'd1);
        apply_stimulus(1'b0, 1'b1);
        check_output("drop_disp", 32'(disp_buf), 32'd0);

        // Same buffer is rewritten from its base, this time to completion
        wr_fill = 10'd600;
        for (int i = 0; i < 600; i++) wait_burst(1'b0, 600 + i, $sformatf("wr1b_%0d", i));
        go_quiet();

        // Both frame starts together: display jumps to the just-written buffer 1
        apply_stimulus(1'b1, 1'b1);
        check_output("both_disp", 32'(disp_buf), 32'd1);
        check_output("both_drops", 32'(frame_drops), 32'd1);
        apply_stimulus(1'b0, 1'b1);
        check_output("both_nv_clear", 32'(disp_buf), 32'd1);

        // Mixed traffic with a saturated write streak: R, 4xW, R, 4xW, R
        // Reads come from display buffer 1 (600..), writes from buffer 2 (1200..)
        wr_fill = 10'd600;
        rd_fill = 10'd100;
        for (int k = 0; k < 11; k++) begin
            if (k % 5 == 0) wait_burst(1'b1, 600 + k / 5, $sformatf("mix_rd_%0d", k));
            else            wait_burst(1'b0, 1200 + k - k / 5 - 1, $sformatf("mix_wr_%0d", k));
        end
        go_quiet();

        // Controller never acknowledges: ack_err after eight WAIT_ACK cycles
        mode    = 1;
        wr_fill = 10'd600;
        wait_burst(1'b0, 1208, "tmo_first");
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check_output("tmo_before", 32'(ack_err), 32'd0);
        @(posedge clk);
        #1;
        check_output("tmo_set", 32'(ack_err), 32'd1);
        wait_burst(1'b0, 1209, "tmo_retry");

        // Park in WAIT_DONE and pull reset mid-burst
        mode = 2;
        @(posedge clk);
        #1;
        check_output("pre_rst_ackerr", 32'(ack_err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_rw_en", 32'(bus.rw_en), 32'd0);
        check_output("mid_rst_rw", 32'(bus.rw), 32'd0);
        check_output("mid_rst_addr", 32'(bus.f_addr), 32'd0);
        check_output("mid_rst_disp", 32'(disp_buf), 32'd2);
        check_output("mid_rst_drops", 32'(frame_drops), 32'd0);
        check_output("mid_rst_ackerr", 32'(ack_err), 32'd0);
        #3;
        rst_n = 1'b1;
        mode  = 0;

        // First write after reset starts again at buffer 0
        wait_burst(1'b0, 0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
